// File: rtl/demux_1to16_reg.sv
// -----------------------------------------------------------------------------
// demux_1to16_reg
//
// Registered 1-to-N streaming demultiplexer. One WIDTH-bit word per cycle
// arrives on a single valid/ready source and is steered to one of N sinks.
// Every sink owns a one-entry output slot, so a stalled sink only blocks words
// addressed to itself; traffic to the other channels keeps flowing.
//
// Optional feature:
//   DEMUX_BROADCAST_EN  adds input in_bcast. When in_bcast=1 the word is loaded
//                       into every slot at once (in_sel ignored) and is accepted
//                       only when every slot can take it. When the macro is
//                       undefined there is no in_bcast port and no extra logic.
//
// Parameters:
//   N      number of output channels (>= 2, need not be a power of 2)
//   WIDTH  data word width
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset; clears every slot (flag and data)
//   in_data    input word
//   in_sel     destination channel index
//   in_valid   source offers a word
//   in_ready   demux accepts the word this cycle (combinational)
//   in_bcast   (DEMUX_BROADCAST_EN only) load the word into every channel
//   out_data   per-channel slot contents, registered
//   out_valid  per-channel slot full
//   out_ready  per-channel sink accepts
// -----------------------------------------------------------------------------
module demux_1to16_reg #(
  parameter int N     = 16,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [$clog2(N)-1:0]      in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
`ifdef DEMUX_BROADCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [N-1:0][WIDTH-1:0]   out_data,
  output logic [N-1:0]              out_valid,
  input  logic [N-1:0]              out_ready
);

  localparam int SEL_W = $clog2(N);

  logic [N-1:0]            full_q, full_d;
  logic [N-1:0][WIDTH-1:0] data_q, data_d;

  logic [N-1:0] sel_hit;    // one-hot decode of in_sel; all-zero when out of range
  logic [N-1:0] slot_free;  // slot can take a word this cycle (empty or draining)
  logic [N-1:0] load;       // slots written on this edge
  logic         in_ready_uni;
  logic         fire;

  // Decoding against every legal index (rather than comparing in_sel < N)
  // makes an out-of-range select fall out naturally as "no channel hit",
  // which both blocks in_ready and prevents any slot write.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    sel_hit = '0;
    for (int i = 0; i < N; i++) begin
      sel_hit[i] = (in_sel == SEL_W'(i));
    end
  end

  // A slot accepts when empty, or when its current word leaves on this same
  // edge; the latter gives one word per cycle per channel.
  assign slot_free    = ~full_q | out_ready;
  assign in_ready_uni = |(sel_hit & slot_free);

`ifdef DEMUX_BROADCAST_EN
  assign in_ready = in_bcast ? (&slot_free) : in_ready_uni;
  assign fire     = in_valid & in_ready;
  assign load     = fire ? (in_bcast ? {N{1'b1}} : sel_hit) : '0;
`else
  assign in_ready = in_ready_uni;
  assign fire     = in_valid & in_ready;
  assign load     = fire ? sel_hit : '0;
`endif

  // Next state: a loaded slot is full with the new word; otherwise a slot
  // stays full only while its sink is not taking it, and data is held.
  always_comb begin
    full_d = load | (full_q & ~out_ready);
    data_d = data_q;
    for (int i = 0; i < N; i++) begin
      if (load[i]) begin
        data_d[i] = in_data;
      end
    end
  end

  // Data slots are reset along with the flags so an idle channel reads 0
  // after reset; reset has priority, so nothing is captured in a reset cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      full_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_demux_1to16_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1to16_reg
//
// Self-checking bench for demux_1to16_reg (N=16, WIDTH=8). A per-channel
// scoreboard queue receives each word when the bench sees it accepted, and
// the word is popped and compared when the channel drains. A small slot model
// predicts in_ready, out_valid and out_data every cycle.
//
// Inputs change 1 ns after the rising edge; in_ready and drain data are sampled
// on the falling edge, registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_demux_1to16_reg;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [W-1:0]        in_data;
  logic [SW-1:0]       in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0][W-1:0] out_data;
  logic [N-1:0]        out_valid;
  logic [N-1:0]        out_ready;
`ifdef DEMUX_BROADCAST_EN
  logic                in_bcast;
`endif

  always #5 clk = ~clk;

  demux_1to16_reg #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slot model and scoreboard.
  logic [N-1:0] m_full;
  logic [W-1:0] m_data [N];
  typedef logic [W-1:0] word_q_t [$];
  word_q_t sb [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
`ifdef DEMUX_BROADCAST_EN
    if (in_bcast) begin
      logic r;
      r = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (m_full[i] && !out_ready[i]) r = 1'b0;
      end
      return r;
    end
`endif
    return !m_full[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic is_bcast();
`ifdef DEMUX_BROADCAST_EN
    return in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle with full checking of in_ready, drained words and the
  // registered slot contents.
  task automatic tick(input string tag);
    logic         fire;
    logic [N-1:0] drain;
    logic [W-1:0] w;
    @(negedge clk);
    check($sformatf("%s.in_ready", tag), {31'd0, in_ready}, {31'd0, model_ready()});
    fire  = in_valid && model_ready() && !reset;
    drain = reset ? '0 : (m_full & out_ready);
    for (int i = 0; i < N; i++) begin
      if (drain[i]) begin
        if (sb[i].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s.sb%0d: drain with empty scoreboard", tag, i);
        end else begin
          w = sb[i].pop_front();
          check($sformatf("%s.drain%0d", tag, i), {24'd0, out_data[i]}, {24'd0, w});
        end
      end
    end
    if (reset) begin
      for (int i = 0; i < N; i++) sb[i].delete();
    end else if (fire) begin
      for (int i = 0; i < N; i++) begin
        if (is_bcast() || in_sel == SW'(i)) sb[i].push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_full = '0;
      for (int i = 0; i < N; i++) m_data[i] = '0;
    end else begin
      m_full = m_full & ~drain;
      if (fire) begin
        for (int i = 0; i < N; i++) begin
          if (is_bcast() || in_sel == SW'(i)) begin
            m_full[i] = 1'b1;
            m_data[i] = in_data;
          end
        end
      end
    end
    check($sformatf("%s.out_valid", tag), {16'd0, out_valid}, {16'd0, m_full});
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.out_data%0d", tag, i), {24'd0, out_data[i]}, {24'd0, m_data[i]});
    end
  endtask

  initial begin
    m_full    = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 4'd5;
    in_data   = 8'hEE;
    out_ready = '0;
`ifdef DEMUX_BROADCAST_EN
    in_bcast  = 1'b0;
`endif

    // 1. Reset for two cycles with in_valid held high: nothing captured.
    @(posedge clk);
    #1;
    tick("reset");
    check("reset.valid0", {16'd0, out_valid}, 32'h0);
    check("reset.data5",  {24'd0, out_data[5]}, 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;

    // 2. Unicast to channel 5.
    in_sel   = 4'd5;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick("uni");
    check("uni.valid",  {16'd0, out_valid}, 32'h0020);
    check("uni.data5",  {24'd0, out_data[5]}, 32'hA5);

    // 3. Backpressure: channel 5 full and stalled, new word must wait.
    in_data = 8'h3C;
    tick("bp.stall");
    check("bp.held", {24'd0, out_data[5]}, 32'hA5);
    out_ready[5] = 1'b1;
    tick("bp.refill");
    check("bp.data5",  {24'd0, out_data[5]}, 32'h3C);
    check("bp.valid5", {31'd0, out_valid[5]}, 32'h1);
    in_valid = 1'b0;
    tick("bp.drain");

    // 4. Streaming words 1..10 into channel 0 with the sink always ready.
    out_ready = '0;
    out_ready[0] = 1'b1;
    in_sel = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      in_data  = W'(k);
      in_valid = 1'b1;
      tick($sformatf("stream%0d", k));
      check($sformatf("stream%0d.data0", k), {24'd0, out_data[0]}, k);
    end
    in_valid = 1'b0;
    tick("stream.tail");

    // 5. Isolation: channel 3 stalled while 0, 7, 15 are served.
    out_ready = '0;
    in_valid  = 1'b1;
    in_sel    = 4'd3;
    in_data   = 8'h33;
    tick("iso.ch3");
    in_sel = 4'd0;  in_data = 8'h70; tick("iso.ch0");
    in_sel = 4'd7;  in_data = 8'h77; tick("iso.ch7");
    in_sel = 4'd15; in_data = 8'hF5; tick("iso.ch15");
    check("iso.valid",  {16'd0, out_valid}, 32'h8089);
    check("iso.data3",  {24'd0, out_data[3]}, 32'h33);

    // Mixed random traffic with random sink stalls.
    for (int k = 0; k < 60; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = SW'($urandom_range(0, N - 1));
      in_data   = W'($urandom);
      out_ready = N'($urandom);
      tick($sformatf("rnd%0d", k));
    end

    // Mid-operation reset: make sure something is held, then drop it all.
    out_ready = '0;
    in_valid  = 1'b1;
    in_sel    = 4'd9;
    in_data   = 8'h99;
    tick("pre_rst");
    reset = 1'b1;
    tick("mid_rst");
    check("mid_rst.valid", {16'd0, out_valid}, 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick("post_rst");

`ifdef DEMUX_BROADCAST_EN
    // 6. Broadcast into all-empty slots, then blocked by a stalled channel 9.
    in_bcast  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = '0;
    tick("bc.fill");
    check("bc.valid", {16'd0, out_valid}, 32'hFFFF);
    check("bc.data12", {24'd0, out_data[12]}, 32'h11);
    out_ready    = '1;
    out_ready[9] = 1'b0;
    in_data      = 8'h22;
    tick("bc.block");
    check("bc.data9", {24'd0, out_data[9]}, 32'h11);
    in_bcast  = 1'b0;
    in_valid  = 1'b0;
    out_ready = '1;
    tick("bc.drain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
